// File: rtl/uart_tx_fifo.sv
// UART transmit buffer and frame sequencer.
// Bytes from the bus are queued in a 2^ADDR_W-deep FIFO. They are handed to
// the transmitter one frame at a time using a one-cycle tx_start pulse, and
// the next byte is not started until tx_end arrives. A watchdog bounds each
// frame. Sticky error flags stay set until software clears them.
module uart_tx_fifo #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned TO_W   = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              flush,
  input  logic              clr_err,
  input  logic              tx_busy,
  input  logic              tx_end,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              tx_active,
  output logic              ovf_err,
  output logic              to_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_END = 2'd1,
    GAP      = 2'd2
  } state_t;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  state_t            state_q, state_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              start_q, start_d;
  logic [7:0]        data_q, data_d;
  logic              ovf_q, to_q;
  logic              pop, push, ovf_ev, to_ev;

  assign fifo_count = count_q;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign tx_active  = (state_q != IDLE);
  assign tx_start   = start_q;
  assign tx_data    = data_q;
  assign ovf_err    = ovf_q;
  assign to_err     = to_q;

  // A pop happens only when a frame is launched. Flush blocks both push and pop.
  // A push into a full FIFO is still accepted when a pop happens in the same cycle.
  assign pop    = (state_q == IDLE) && !fifo_empty && !tx_busy && !flush;
  assign push   = wr_en && !flush && (!fifo_full || pop);
  assign ovf_ev = wr_en && !flush && fifo_full && !pop;

  // Next-count: flush wins; a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  // Byte storage. It has no reset because the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Frame sequencer next-state logic: launch, wait for end or watchdog, one gap cycle.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = data_q;
    wd_d    = wd_q;
    to_ev   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          start_d = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          wd_d    = '0;
          state_d = WAIT_END;
        end
      end
      WAIT_END: begin
        if (tx_end) begin
          state_d = GAP;
        end else if (wd_q == '1) begin
          to_ev   = 1'b1;
          state_d = GAP;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sequencer registers and the start pulse / data holding register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wd_q    <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      start_q <= start_d;
      data_q  <= data_d;
    end
  end

  // Sticky error flags. An error event in the same cycle overrides clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      if (ovf_ev)       ovf_q <= 1'b1;
      else if (clr_err) ovf_q <= 1'b0;
      if (to_ev)        to_q  <= 1'b1;
      else if (clr_err) to_q  <= 1'b0;
    end
  end

endmodule
